spi_ram_responder: RTL
======================

// Module: spi_ram_responder
// PURPOSE
// SPI mode-0 responder emulating the serial SRAM on the femto SPI RAM port: the
// far end of spi_clk_ram/spi_cs_n_ram/spi_mosi_ram/spi_miso_ram. Decodes READ
// (0x03) and WRITE (0x02) with a 24-bit address into an internal byte array.
// Used on-FPGA/in-bench as a stand-in for the external RAM chip.
// SPI pins are oversampled in the clk domain; clk must be >= 4x SCK.
// PARAMETERS
// ADDR_W   10   byte-address bits kept; the array is 2**ADDR_W bytes.
//               Upper address bits are ignored, so the address aliases modulo the size.
// SYNC_FF  2    synchronizer depth on sck, cs_n and mosi; legal values 2..3.
// PORTS
// clk        in   1  system clock; all logic on posedge
// reset      in   1  synchronous, active-high reset
// spi_clk    in   1  SCK from the initiator, idle low (mode 0)
// spi_cs_n   in   1  chip select, active low
// spi_mosi   in   1  initiator -> responder data, MSB first
// spi_miso   out  1  responder -> initiator data, MSB first
// busy       out  1  high while cs_n (synchronized) is low
// cmd_err    out  1  one-clk pulse when an unsupported opcode is received
// BEHAVIOUR
// - Reset: spi_miso=0, busy=0, cmd_err=0, state=IDLE, counters cleared.
//   Array contents are NOT cleared.
// - Synchronized sck/cs_n/mosi pass through SYNC_FF flops plus one edge-detect flop.
//   sck_rise/sck_fall are 1-clk pulses.
//   Input-to-action latency is SYNC_FF+1 clk.
// - mosi is sampled on sck_rise. The miso shift register advances on sck_fall.
// - States: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
//   IDLE -> CMD on synced cs_n falling; bit_cnt=0.
//   CMD: shift 8 bits.
//     0x03 or 0x02 -> ADDR.
//     Any other opcode -> IGNORE, and cmd_err pulses in the clk after the 8th sck_rise.
//   ADDR: shift 24 bits; keep the low ADDR_W bits as addr.
//     On the 24th bit, opcode 0x02 -> WRITE.
//     On the 24th bit, opcode 0x03 -> READ, and mem[addr] is loaded into tx_sr
//     in the same clk, with spi_miso = tx_sr[7] immediately.
//   READ: on each sck_fall, shift tx_sr left.
//     After the 8th fall of a byte: addr <= addr+1 (wraps 2**ADDR_W-1 -> 0),
//     tx_sr <= mem[addr+1], so the MSB is valid before the next rise.
//   WRITE: shift 8 mosi bits.
//     On the 8th rise: mem[addr] <= byte; addr <= addr+1 with the same wrap.
//     Unlimited burst.
//   IGNORE: discard all sck activity until cs_n rises.
// - Any state -> IDLE in the clk the synced cs_n is seen high.
//   A partial write byte is discarded (no array write). bit_cnt is cleared.
//   spi_miso returns to 0.
// - spi_miso is 0 in IDLE/CMD/ADDR/WRITE/IGNORE and carries tx_sr[7] only in READ.
// - sck edges while cs_n is high are ignored.
// - cs_n rise and sck edge in the same clk: cs_n wins and the edge is dropped.
// - Reset asserted mid-transaction: state -> IDLE next clk. No array write.
//   Outputs return to reset values.
// - cmd_err never pulses for 0x02/0x03 or for a transaction truncated inside CMD.
// TESTING
// 1. Write 0x02,0x000010,0xA5,0x3C then cs_n high
//    -> mem[0x10]=0xA5, mem[0x11]=0x3C; busy high for exactly the cs_n-low window (+latency).
// 2. Read 0x03,0x000010 then 16 SCK
//    -> miso returns 0xA5 then 0x3C, MSB first, each bit valid at sck rise.
// 3. Write 0xFF,0x11 at address 2**ADDR_W-1, then read 2 bytes from 0x3FF (ADDR_W=10)
//    -> wrap: mem[0x3FF]=0xFF, mem[0x000]=0x11; read returns 0xFF,0x11.
// 4. Opcode 0x9F followed by 32 SCK
//    -> cmd_err single-clk pulse, miso stays 0, no array change.
// 5. WRITE 0x02,0x000020, 5 data bits, then cs_n high; next, READ 0x000020
//    -> original mem[0x20] unchanged, state back in IDLE.
// 6. Assert reset during READ byte 1
//    -> next clk spi_miso=0, busy=0. A new READ after release returns correct data.

Source files
------------

// File: rtl/spi_ram_if.sv
// SPI mode-0 link between an initiator (master) and the RAM responder (slave).
// Protocol: cs_n low frames a transaction, SCK idles low, both data lines are MSB first,
// mosi is captured on SCK rise and miso changes after SCK fall.
interface spi_ram_if;
  logic spi_clk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_clk, output spi_cs_n, output spi_mosi, input spi_miso);
  modport slave  (input spi_clk, input spi_cs_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_ram_responder.sv
// Serial SRAM stand-in: oversamples the SPI pins in the clk domain and services
// READ (0x03) / WRITE (0x02) with a 24-bit address into a 2**ADDR_W byte array.
module spi_ram_responder #(
  parameter int ADDR_W  = 10,
  parameter int SYNC_FF = 2   // 2..3
) (
  input  logic          clk,
  input  logic          reset,
  spi_ram_if.slave      bus,
  output logic          busy,
  output logic          cmd_err,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    READ   = 3'd3,
    WRITE  = 3'd4,
    IGNORE = 3'd5
  } state_t;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  logic [SYNC_FF-1:0] sck_sync, cs_sync, mosi_sync;
  logic               sck_d, cs_d;
  logic               sck_s, cs_s, mosi_s;
  logic               sck_rise, sck_fall, cs_fall;

  state_t             state, state_n;
  logic [4:0]         bit_cnt, bit_cnt_n;
  logic [7:0]         opcode, opcode_n;
  logic [ADDR_W-1:0]  addr, addr_n, rd_addr;
  logic [7:0]         tx_sr, tx_n;
  logic [6:0]         rx_sr, rx_n;
  logic               seen_rise, seen_rise_n;
  logic               cmd_err_n;
  logic               tx_load;
  logic               mem_we;
  logic [7:0]         mem_wdata;

  logic [7:0]         mem [2**ADDR_W];

  // Reset parks the synchronizers at the idle pin levels so no edge is seen on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_FF-2:0], bus.spi_clk};
      cs_sync   <= {cs_sync[SYNC_FF-2:0], bus.spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_FF-2:0], bus.spi_mosi};
      sck_d     <= sck_sync[SYNC_FF-1];
      cs_d      <= cs_sync[SYNC_FF-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_FF-1];
  assign cs_s     = cs_sync[SYNC_FF-1];
  assign mosi_s   = mosi_sync[SYNC_FF-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    opcode_n    = opcode;
    addr_n      = addr;
    tx_n        = tx_sr;
    rx_n        = rx_sr;
    seen_rise_n = seen_rise;
    cmd_err_n   = 1'b0;
    tx_load     = 1'b0;
    rd_addr     = addr;
    mem_we      = 1'b0;
    mem_wdata   = {rx_sr, mosi_s};

    // cs_n high overrides any SCK edge in the same clk; a partial byte is dropped.
    if (state != IDLE && cs_s) begin
      state_n     = IDLE;
      bit_cnt_n   = 5'd0;
      seen_rise_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state_n   = CMD;
            bit_cnt_n = 5'd0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            opcode_n  = {opcode[6:0], mosi_s};
            bit_cnt_n = bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt_n = 5'd0;
              if (opcode_n == OP_READ || opcode_n == OP_WRITE) begin
                state_n = ADDR;
              end else begin
                state_n   = IGNORE;
                cmd_err_n = 1'b1;
              end
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            addr_n    = {addr[ADDR_W-2:0], mosi_s};
            bit_cnt_n = bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              bit_cnt_n   = 5'd0;
              seen_rise_n = 1'b0;
              if (opcode == OP_READ) begin
                state_n = READ;
                tx_load = 1'b1;
                rd_addr = addr_n;
              end else begin
                state_n = WRITE;
              end
            end
          end
        end
        READ: begin
          // Only a fall that follows a data-bit rise shifts, so the fall right after
          // the last address bit does not consume the first data MSB.
          if (sck_rise) begin
            seen_rise_n = 1'b1;
          end else if (sck_fall && seen_rise) begin
            seen_rise_n = 1'b0;
            tx_n        = {tx_sr[6:0], 1'b0};
            bit_cnt_n   = bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt_n = 5'd0;
              addr_n    = addr + ADDR_W'(1);
              rd_addr   = addr_n;
              tx_load   = 1'b1;
            end
          end
        end
        WRITE: begin
          if (sck_rise) begin
            rx_n      = {rx_sr[5:0], mosi_s};
            bit_cnt_n = bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt_n = 5'd0;
              mem_we    = 1'b1;
              addr_n    = addr + ADDR_W'(1);
            end
          end
        end
        IGNORE: begin
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 5'd0;
      opcode    <= 8'd0;
      addr      <= '0;
      tx_sr     <= 8'd0;
      rx_sr     <= 7'd0;
      seen_rise <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      opcode    <= opcode_n;
      addr      <= addr_n;
      tx_sr     <= tx_load ? mem[rd_addr] : tx_n;
      rx_sr     <= rx_n;
      seen_rise <= seen_rise_n;
      cmd_err   <= cmd_err_n;
    end
  end

  // Array has no reset; writes are simply suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[addr] <= mem_wdata;
    end
  end

  assign bus.spi_miso = (state == READ) ? tx_sr[7] : 1'b0;
  assign busy         = ~cs_s;
  assign state_dbg    = state;

endmodule
